// File: rtl/jmp_seq_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : jmp_seq_checker_if
//  Purpose  : Count stream and status bundle for the jump-sequence checker.
//             The master drives the stream; the slave (checker) reports.
//  Revision : 1.0  initial release
// ============================================================================
interface jmp_seq_checker_if #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8
);
  logic [WIDTH-1:0]     count_in;
  logic                 count_valid;
  logic                 locked;
  logic                 seq_err;
  logic                 illegal;
  logic [WIDTH-1:0]     expected;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output count_in, count_valid,
    input  locked, seq_err, illegal, expected, err_count
  );

  modport slave (
    input  count_in, count_valid,
    output locked, seq_err, illegal, expected, err_count
  );
endinterface
`default_nettype wire

// File: rtl/jmp_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : jmp_seq_checker
//  Purpose  : Receive-side monitor for the jump-counter sequence. Locks onto
//             the sampled count stream, pulses on sequence breaks and on
//             values inside the skipped range, keeps a saturating error count.
//  Revision : 1.0  initial release
// ============================================================================
module jmp_seq_checker #(
  parameter int WIDTH      = 4,
  parameter int JMP_FROM   = 6,
  parameter int JMP_TO     = 9,
  parameter int LOCK_COUNT = 2,
  parameter int ERR_CNT_W  = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  jmp_seq_checker_if.slave   bus
);

  localparam int                 MC_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [MC_W-1:0]    C_LOCK  = MC_W'(LOCK_COUNT);
  localparam logic [WIDTH-1:0]   C_FROM  = WIDTH'(JMP_FROM);
  localparam logic [WIDTH-1:0]   C_TO    = WIDTH'(JMP_TO);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [MC_W-1:0]      match_cnt_q, match_cnt_d;
  logic                 locked_q,    locked_d;
  logic                 seq_err_q,   seq_err_d;
  logic                 illegal_q,   illegal_d;
  logic [WIDTH-1:0]     expected_q,  expected_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  // Successor of a legal value; the all-ones wrap falls out of WIDTH-bit add.
  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] v);
    if (v == C_FROM) nxt = C_TO;
    else             nxt = v + WIDTH'(1);
  endfunction

  // Values strictly between the jump endpoints never appear in a good stream.
  function automatic logic is_illegal(input logic [WIDTH-1:0] v);
    is_illegal = (v > C_FROM) && (v < C_TO);
  endfunction

  logic w_ill;
  logic w_match;
  logic w_err_sat;
  assign w_ill     = is_illegal(bus.count_in);
  assign w_match   = (bus.count_in == expected_q);
  assign w_err_sat = (err_count_q == {ERR_CNT_W{1'b1}});

  // Register all state and outputs; reset wins over any sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      match_cnt_q <= '0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      illegal_q   <= 1'b0;
      expected_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      illegal_q   <= illegal_d;
      expected_q  <= expected_d;
      err_count_q <= err_count_d;
    end
  end

  // Next-state: everything holds without a sample, pulses always clear.
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    locked_d    = locked_q;
    seq_err_d   = 1'b0;
    illegal_d   = 1'b0;
    expected_d  = expected_q;
    err_count_d = err_count_q;

    if (bus.count_valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (w_ill) begin
            illegal_d = 1'b1;
          end else begin
            state_d     = ST_CONFIRM;
            match_cnt_d = '0;
            expected_d  = nxt(bus.count_in);
          end
        end
        ST_CONFIRM: begin
          if (w_ill) begin
            illegal_d   = 1'b1;
            state_d     = ST_HUNT;
            match_cnt_d = '0;
            expected_d  = '0;
          end else if (w_match) begin
            expected_d = nxt(bus.count_in);
            if (match_cnt_q + MC_W'(1) == C_LOCK) begin
              state_d     = ST_LOCKED;
              locked_d    = 1'b1;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MC_W'(1);
            end
          end else begin
            match_cnt_d = '0;
            expected_d  = nxt(bus.count_in);
          end
        end
        ST_LOCKED: begin
          if (w_match && !w_ill) begin
            expected_d = nxt(bus.count_in);
          end else begin
            // Any break while locked is a counted sequence error.
            seq_err_d   = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            if (!w_err_sat) err_count_d = err_count_q + ERR_CNT_W'(1);
            if (w_ill) begin
              illegal_d  = 1'b1;
              state_d    = ST_HUNT;
              expected_d = '0;
            end else begin
              state_d    = ST_CONFIRM;
              expected_d = nxt(bus.count_in);
            end
          end
        end
        default: begin
          state_d     = ST_HUNT;
          match_cnt_d = '0;
          locked_d    = 1'b0;
          expected_d  = '0;
        end
      endcase
    end
  end

  assign bus.locked    = locked_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.illegal   = illegal_q;
  assign bus.expected  = expected_q;
  assign bus.err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_jmp_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jmp_seq_checker
//  Purpose  : Self-checking bench for jmp_seq_checker. Two instances share one
//             stimulus stream: default parameters, and a 2-bit error counter
//             to exercise saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jmp_seq_checker;

  localparam int W    = 4;
  localparam int JF   = 6;
  localparam int JT   = 9;
  localparam int LOCK = 2;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  jmp_seq_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) ifa ();
  jmp_seq_checker_if #(.WIDTH(W), .ERR_CNT_W(2)) ifb ();

  jmp_seq_checker #(.WIDTH(W), .JMP_FROM(JF), .JMP_TO(JT), .LOCK_COUNT(LOCK),
                    .ERR_CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  jmp_seq_checker #(.WIDTH(W), .JMP_FROM(JF), .JMP_TO(JT), .LOCK_COUNT(LOCK),
                    .ERR_CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: "have_ref" = a legal value has been seen since the last
  // reset/illegal; "streak" = consecutive correct successors since then.
  bit m_have;
  int m_streak;
  int m_exp;
  bit m_locked;
  int m_errs;
  bit m_se;
  bit m_ill;

  function automatic int succ(input int v);
    if (v == JF) return JT;
    return (v + 1) % (1 << W);
  endfunction

  function automatic bit bad_val(input int v);
    return (v > JF) && (v < JT);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model(input bit r, input bit vld, input int v);
    m_se  = 1'b0;
    m_ill = 1'b0;
    if (r) begin
      m_have = 0; m_streak = 0; m_exp = 0; m_locked = 0; m_errs = 0;
    end else if (vld) begin
      if (bad_val(v)) begin
        m_ill = 1'b1;
        if (m_locked) begin m_se = 1'b1; m_errs++; end
        m_have = 0; m_streak = 0; m_exp = 0; m_locked = 0;
      end else if (!m_have) begin
        m_have = 1; m_streak = 0; m_exp = succ(v);
      end else if (v == m_exp) begin
        m_streak++;
        m_exp = succ(v);
        if (m_streak >= LOCK) m_locked = 1;
      end else begin
        if (m_locked) begin m_se = 1'b1; m_errs++; end
        m_locked = 0; m_streak = 0; m_exp = succ(v);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, then compare one time unit after the edge.
  task automatic step(input bit r, input bit vld, input int v);
    reset           = r;
    ifa.count_valid = vld;
    ifb.count_valid = vld;
    ifa.count_in    = W'(v);
    ifb.count_in    = W'(v);
    @(posedge clk);
    model(r, vld, v);
    #1;
    check("locked",    32'(ifa.locked),    32'(m_locked));
    check("seq_err",   32'(ifa.seq_err),   32'(m_se));
    check("illegal",   32'(ifa.illegal),   32'(m_ill));
    check("expected",  32'(ifa.expected),  32'(m_exp));
    check("err_count", 32'(ifa.err_count), 32'(sat(m_errs, 255)));
    check("err_sat2",  32'(ifb.err_count), 32'(sat(m_errs, 3)));
    check("locked_b",  32'(ifb.locked),    32'(m_locked));
  endtask

  initial begin
    reset = 1'b1;
    ifa.count_valid = 1'b0; ifb.count_valid = 1'b0;
    ifa.count_in = '0;      ifb.count_in = '0;

    // Reset state
    step(1, 0, 0);
    step(1, 1, 5);
    check("rst_expected", 32'(ifa.expected), 32'd0);

    // Lock-up 0,1,2,3
    step(0, 1, 0);
    step(0, 1, 1);
    check("pre_lock", 32'(ifa.locked), 32'd0);
    step(0, 1, 2);
    check("lock_after_2", 32'(ifa.locked), 32'd1);
    check("exp_3", 32'(ifa.expected), 32'd3);
    step(0, 1, 3);

    // Jump 4,5,6,9,10
    step(0, 1, 4);
    step(0, 1, 5);
    step(0, 1, 6);
    check("exp_jump", 32'(ifa.expected), 32'd9);
    step(0, 1, 9);
    step(0, 1, 10);
    check("exp_11", 32'(ifa.expected), 32'd11);

    // Break: 12 instead of 11
    step(0, 1, 12);
    check("brk_seq_err", 32'(ifa.seq_err), 32'd1);
    check("brk_errcnt", 32'(ifa.err_count), 32'd1);
    check("brk_exp", 32'(ifa.expected), 32'd13);
    step(0, 1, 13);
    step(0, 1, 14);
    check("relock", 32'(ifa.locked), 32'd1);

    // Wrap 15,0,1
    step(0, 1, 15);
    check("exp_wrap", 32'(ifa.expected), 32'd0);
    step(0, 1, 0);
    step(0, 1, 1);

    // Illegal while locked after 6
    step(0, 1, 2); step(0, 1, 3); step(0, 1, 4); step(0, 1, 5); step(0, 1, 6);
    step(0, 1, 7);
    check("ill_both", 32'({ifa.seq_err, ifa.illegal}), 32'd3);
    step(0, 0, 0);
    check("ill_clear", 32'({ifa.seq_err, ifa.illegal}), 32'd0);
    step(0, 1, 8);
    check("hunt_ill_only", 32'({ifa.seq_err, ifa.illegal}), 32'd1);

    // Gaps between samples of a locked stream
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 0, 11);
    step(0, 1, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 7);
    step(0, 1, 4);
    check("gap_locked", 32'(ifa.locked), 32'd1);

    // Five breaks -> 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0); step(0, 1, 1); step(0, 1, 2); step(0, 1, 12);
    end
    check("sat_at_3", 32'(ifb.err_count), 32'd3);

    // Reset mid-lock with a mismatching sample
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
    step(1, 1, 13);
    check("rst_mid_seq_err", 32'(ifa.seq_err), 32'd0);
    check("rst_mid_errcnt", 32'(ifa.err_count), 32'd0);
    step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
    check("relock_rst", 32'(ifa.locked), 32'd1);

    // Randomized stream, mostly following the expected sequence
    for (int i = 0; i < 3000; i++) begin
      int v;
      bit vld;
      bit r;
      r   = ($urandom_range(0, 199) == 0);
      vld = ($urandom_range(0, 3) != 0);
      if (m_have && $urandom_range(0, 9) < 8) v = m_exp;
      else                                    v = int'($urandom_range(0, 15));
      step(r, vld, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jmp_seq_checker.md
Name: jmp_seq_checker

Overview:
- Receive-side monitor for the jump-counter sequence. It samples a 4-bit (parameterisable) count stream and checks that each value follows the jump rule: +1, except JMP_FROM→JMP_TO and all-ones→0.
- Locks onto the stream and flags sequence and illegal-value errors.
- Keeps a saturating error count for debug and LED display.

Parameters:
- WIDTH, 4, width of the observed count.
- JMP_FROM, 6, value after which the sequence jumps. Constraint: JMP_FROM < JMP_TO.
- JMP_TO, 9, target of the jump. Constraint: JMP_TO ≤ 2^WIDTH−1.
- LOCK_COUNT, 2, consecutive correct successors required to lock (≥1).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- count_in  in  WIDTH  observed counter value.
- count_valid  in  1  count_in is sampled on this cycle when high.
- locked  out  1  checker is synchronised to the stream.
- seq_err  out  1  one-cycle pulse: locked stream broke sequence or carried an illegal value.
- illegal  out  1  one-cycle pulse: sampled value lies in the skipped range (JMP_FROM, JMP_TO).
- expected  out  WIDTH  next value the checker expects; 0 in HUNT.
- err_count  out  ERR_CNT_W  saturating count of seq_err pulses.

Behaviour:
- Reset and timing:
  - All outputs are registered.
  - reset has priority over count_valid.
  - At the edge where reset is high: state=HUNT, match_cnt=0, locked=0, seq_err=0, illegal=0, expected=0, err_count=0.
  - Reset mid-operation discards lock and error history.
- Successor function nxt(v):
  - v==JMP_FROM → JMP_TO.
  - v==2^WIDTH−1 → 0.
  - otherwise v+1, computed in WIDTH bits.
- Illegal value: JMP_FROM < v < JMP_TO. With the default parameters, 7 and 8 are illegal.
- Latency: the response to a sample on edge N is visible after edge N. Outputs change only on cycles with count_valid=1, except the pulses.
- seq_err and illegal are high for exactly one cycle after the offending sample, then return to 0. They deassert even if count_valid stays low.
- count_valid=0: state, match_cnt, expected and err_count hold. Gaps are not errors.
- State HUNT:
  - Legal sample v → CONFIRM, match_cnt=0, expected=nxt(v).
  - Illegal sample → illegal pulse, stay in HUNT, no seq_err, err_count unchanged.
- State CONFIRM:
  - Sample == expected → match_cnt+1, expected=nxt(v).
  - If match_cnt+1 == LOCK_COUNT → LOCKED, locked=1.
  - Legal mismatch → restart: match_cnt=0, expected=nxt(v). No seq_err.
  - Illegal sample → illegal pulse, go to HUNT, expected=0. No seq_err.
- State LOCKED:
  - Sample == expected → stay, expected=nxt(v).
  - Legal mismatch → seq_err pulse, err_count+1, locked=0, go to CONFIRM with match_cnt=0, expected=nxt(v).
  - Illegal sample → seq_err and illegal pulse together, err_count+1, locked=0, go to HUNT, expected=0.
- err_count saturates at 2^ERR_CNT_W−1 and never wraps.
- Wrap-around: 2^WIDTH−1 followed by 0 is correct, not an error.
- JMP_FROM followed by JMP_FROM+1 is an error, unless JMP_TO==JMP_FROM+1. JMP_TO==JMP_FROM+1 degenerates to a plain counter with no illegal values.

Test Plan:
1. Lock-up: reset, then valid 0,1,2,3 on consecutive cycles → locked=1 after the edge sampling 2; expected=3, then 4; no pulses.
2. Jump and wrap:
   - Locked, feed 5,6,9,10 → expected 6,9,10,11, no errors.
   - Then 14,15,0,1 from a fresh lock → no errors; expected=0 after 15.
3. Sequence break:
   - Locked with expected=11, feed 12 → one-cycle seq_err, err_count=1, locked=0, expected=13.
   - Then 13,14 → locked=1 again.
4. Illegal value: locked after 6, feed 7 → seq_err=1 and illegal=1 for one cycle, err_count+1, locked=0, expected=0 (HUNT).
   - Feeding 8 in HUNT → illegal pulse only, err_count unchanged.
5. Gaps and saturation:
   - Locked stream with count_valid low 3 cycles between samples → no errors; outputs hold.
   - With ERR_CNT_W=2, force 5 breaks → err_count stops at 3.
6. Reset mid-lock: reset=1 with count_valid=1 carrying a mismatch → next cycle locked=0, err_count=0, expected=0, no seq_err; relocks per scenario 1 after reset drops.
